// File: rtl/timer_display_if.sv
// Signal bundle between the countdown timer (master) and the display scanner (slave).
// There is no valid/ready: the timer holds its digits steady and the scanner samples them once per frame.
interface timer_display_if;
   logic [3:0] val0;
   logic [3:0] val1;
   logic [3:0] val2;
   logic [3:0] val3;
   logic       stop;
   logic [3:0] ssd_ctl;
   logic [7:0] ssd_out;

   modport master (
      output val0, val1, val2, val3, stop,
      input  ssd_ctl, ssd_out
   );

   modport slave (
      input  val0, val1, val2, val3, stop,
      output ssd_ctl, ssd_out
   );
endinterface

// File: rtl/timer_display.sv
// Four-digit common-anode MM:SS scanner with per-frame input capture,
// minutes-tens zero blanking, colon on digit 2 and blinking while stopped.
module timer_display #(
   parameter int SCAN_DIV     = 25000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic            clk,
   input  logic            rst_n,
   timer_display_if.slave  bus
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SW-1:0] SCNT_MAX = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_FRAMES - 1);

   logic [SW-1:0]     scnt;
   logic [1:0]        sel;
   logic [3:0][3:0]   sh_val;
   logic              sh_stop;
   logic [BW-1:0]     bcnt;
   logic              phase;
   logic              frame;
   logic [3:0]        digit;
   logic [6:0]        seg;
   logic              blank;
   logic [3:0]        ctl_next;
   logic [7:0]        out_next;

   assign frame = (scnt == '0) && (sel == 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt <= '0;
         sel  <= 2'd0;
      end else if (scnt == SCNT_MAX) begin
         scnt <= '0;
         sel  <= sel + 2'd1;
      end else begin
         scnt <= scnt + 1'b1;
      end
   end

   // The live stop decides a clear so the display comes back from the capturing
   // boundary; the previous shadow stop decides whether the blink count runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_val  <= '0;
         sh_stop <= 1'b0;
         bcnt    <= '0;
         phase   <= 1'b1;
      end else if (frame) begin
         sh_val  <= {bus.val3, bus.val2, bus.val1, bus.val0};
         sh_stop <= bus.stop;
         if (!bus.stop) begin
            bcnt  <= '0;
            phase <= 1'b1;
         end else if (sh_stop) begin
            if (bcnt == BCNT_MAX) begin
               bcnt  <= '0;
               phase <= ~phase;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      digit = sh_val[sel];
      seg   = 7'b1111110;
      case (digit)
         4'd0: seg = 7'b0000001;
         4'd1: seg = 7'b1001111;
         4'd2: seg = 7'b0010010;
         4'd3: seg = 7'b0000110;
         4'd4: seg = 7'b1001100;
         4'd5: seg = 7'b0100100;
         4'd6: seg = 7'b0100000;
         4'd7: seg = 7'b0001111;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0000100;
         default: seg = 7'b1111110;
      endcase
      blank = !phase || ((sel == 2'd3) && (sh_val[3] == 4'd0));
      if (blank) begin
         ctl_next = 4'b1111;
         out_next = 8'hFF;
      end else begin
         ctl_next = ~(4'b0001 << sel);
         out_next = {seg, (sel != 2'd2)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ssd_ctl <= 4'b1111;
         bus.ssd_out <= 8'hFF;
      end else begin
         bus.ssd_ctl <= ctl_next;
         bus.ssd_out <= out_next;
      end
   end

endmodule

// File: tb/tb_timer_display.sv
// Randomised bench for timer_display against a frame-level reference model.
module tb_timer_display;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 4 * SD;
  localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100};

  logic clk;
  logic rst_n;
  timer_display_if bus ();

  timer_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;                // edges since reset release
  logic [16:0] caps[$];     // {stop, val3, val2, val1, val0} captured per frame

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h required %h", tag, t, got, exp);
    end
  endtask

  // reference model: frame f is visible unless it lies in an odd block of BF
  // frames counted from the first frame of its current stop run
  function automatic bit visible(input int fs);
    int s;
    if (!caps[fs][16]) return 1'b1;
    s = fs;
    while (s > 0 && caps[s-1][16]) s--;
    return ((fs - s) / BF) % 2 == 0;
  endfunction

  function automatic void expect_at(input int te, output logic [3:0] ctl, output logic [7:0] out);
    int c;
    int d;
    int fs;
    logic [16:0] cap;
    logic [3:0] v;
    bit vis;
    c = te - 1;
    d = (c / SD) % 4;
    if (c == 0) begin
      cap = '0;
      vis = 1'b1;
    end else begin
      fs = (c - 1) / FR;
      cap = caps[fs];
      vis = visible(fs);
    end
    v = cap[4*d +: 4];
    if (!vis || (d == 3 && v == 4'd0)) begin
      ctl = 4'b1111;
      out = 8'hFF;
    end else begin
      ctl = 4'b1111;
      ctl[d] = 1'b0;
      out = {(v > 4'd9) ? 7'b1111110 : SEG[v], (d != 2)};
    end
  endfunction

  // driver tasks
  task automatic cycle();
    logic [3:0] ec;
    logic [7:0] eo;
    if (t % FR == 0) caps.push_back({bus.stop, bus.val3, bus.val2, bus.val1, bus.val0});
    @(posedge clk);
    t++;
    @(negedge clk);
    expect_at(t, ec, eo);
    check("ssd_ctl", {4'b0, bus.ssd_ctl}, {4'b0, ec});
    check("ssd_out", bus.ssd_out, eo);
    check("one_hot_ctl", {7'b0, ($countones(~bus.ssd_ctl) <= 1)}, 8'd1);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n * FR; i++) cycle();
  endtask

  task automatic set_vals(input logic [3:0] v3, v2, v1, v0, input logic s);
    bus.val3 = v3; bus.val2 = v2; bus.val1 = v1; bus.val0 = v0; bus.stop = s;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {4'b0, bus.ssd_ctl}, 8'h0F);
    check("async_rst_out", bus.ssd_out, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    caps.delete();
    check("rel_ctl", {4'b0, bus.ssd_ctl}, 8'h0F);
    check("rel_out", bus.ssd_out, 8'hFF);
  endtask

  initial begin
    logic [3:0] ec;
    logic [7:0] eo;
    int guard;
    rst_n = 1'b0;
    set_vals(0, 2, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {4'b0, bus.ssd_ctl}, 8'h0F);
    check("reset_out", bus.ssd_out, 8'hFF);
    rst_n = 1'b1;

    // 02:00, then reset in the middle of a scan
    run_frames(3);
    for (int i = 0; i < 5; i++) cycle();
    do_reset();
    run_frames(2);

    // frame coherence: change val0 while digit 2 is being scanned
    guard = 0;
    while (((t / SD) % 4) != 2 && guard < 2 * FR) begin
      cycle();
      guard++;
    end
    bus.val0 = 4'd9;
    run_frames(2);

    // invalid BCD on digits 1 and 3
    set_vals(4'hA, 4'd5, 4'hC, 4'd7, 0);
    run_frames(2);

    // stop blink at 00:00, then release
    set_vals(0, 0, 0, 0, 1);
    run_frames(6);
    bus.stop = 1'b0;
    run_frames(2);

    // reset while dark
    bus.stop = 1'b1;
    guard = 0;
    do begin
      cycle();
      guard++;
      expect_at(t, ec, eo);
    end while (!(eo == 8'hFF && ec == 4'hF && (t % FR) == 6) && guard < 12 * FR);
    check("reached_dark", {7'b0, (guard < 12 * FR)}, 8'd1);
    set_vals(1, 2, 3, 4, 1);
    do_reset();
    run_frames(3);

    // randomised traffic
    for (int i = 0; i < 30 * FR; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.val0 = 4'($urandom_range(0, 15));
          1: bus.val1 = 4'($urandom_range(0, 15));
          2: bus.val2 = 4'($urandom_range(0, 15));
          default: bus.val3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 39) == 0) bus.stop = ~bus.stop;
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
